// File: rtl/ext_mem_loader.sv
// Boot loader: streams words into processor memory, holds the core in reset until loaded.
// Optional checksum readback before release is enabled with `define LOADER_VERIFY_EN.
module ext_mem_loader #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_cnt,
    input  logic             in_val,
    input  logic [31:0]      in_data,
    output logic             in_rdy,
    output logic             ext_dmemreq_val,
    output logic             ext_dmemreq_type,
    output logic [31:0]      ext_dmemreq_addr,
    output logic [31:0]      ext_dmemreq_wdata,
    input  logic [31:0]      ext_dmemresp_rdata,
    output logic             proc_rst,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {StIdle, StLoad, StVerify, StRun, StError} state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state_q, state_d;
    logic [31:0]      base_q, base_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [31:0]      req_addr;
    logic             last;

    assign req_addr = base_q + (32'(idx_q) << 2);
    assign last     = (idx_q == cnt_q - CntOne);

`ifdef LOADER_VERIFY_EN
    logic [31:0] sum_q, sum_d;
    logic [31:0] rsum_q, rsum_d;
`else
    logic unused_rdata;
    assign unused_rdata = ^ext_dmemresp_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            base_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
`ifdef LOADER_VERIFY_EN
            sum_q   <= '0;
            rsum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
`ifdef LOADER_VERIFY_EN
            sum_q   <= sum_d;
            rsum_q  <= rsum_d;
`endif
        end
    end

    always_comb begin
        state_d           = state_q;
        base_d            = base_q;
        cnt_d             = cnt_q;
        idx_d             = idx_q;
`ifdef LOADER_VERIFY_EN
        sum_d             = sum_q;
        rsum_d            = rsum_q;
`endif
        in_rdy            = 1'b0;
        ext_dmemreq_val   = 1'b0;
        ext_dmemreq_type  = 1'b0;
        ext_dmemreq_addr  = '0;
        ext_dmemreq_wdata = '0;
        proc_rst          = 1'b1;
        done              = 1'b0;
        error             = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d = {base_addr[31:2], 2'b00};
                    cnt_d  = word_cnt;
                    idx_d  = '0;
`ifdef LOADER_VERIFY_EN
                    sum_d  = '0;
                    rsum_d = '0;
                    state_d = (word_cnt != '0) ? StLoad : StVerify;
`else
                    state_d = (word_cnt != '0) ? StLoad : StRun;
`endif
                end
            end
            StLoad: begin
                in_rdy = 1'b1;
                if (in_val) begin
                    ext_dmemreq_val   = 1'b1;
                    ext_dmemreq_type  = 1'b1;
                    ext_dmemreq_addr  = req_addr;
                    ext_dmemreq_wdata = in_data;
`ifdef LOADER_VERIFY_EN
                    sum_d = sum_q + in_data;
`endif
                    if (last) begin
                        idx_d = '0;
`ifdef LOADER_VERIFY_EN
                        state_d = StVerify;
`else
                        state_d = StRun;
`endif
                    end else begin
                        idx_d = idx_q + CntOne;
                    end
                end
            end
`ifdef LOADER_VERIFY_EN
            StVerify: begin
                if (cnt_q == '0) begin
                    // Empty image: both sums are zero, so it always passes.
                    state_d = StRun;
                end else begin
                    ext_dmemreq_val  = 1'b1;
                    ext_dmemreq_addr = req_addr;
                    rsum_d = rsum_q + ext_dmemresp_rdata;
                    if (last) begin
                        idx_d   = '0;
                        state_d = (rsum_d == sum_q) ? StRun : StError;
                    end else begin
                        idx_d = idx_q + CntOne;
                    end
                end
            end
            StError: begin
                error = 1'b1;
            end
`endif
            StRun: begin
                proc_rst = 1'b0;
                done     = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule
